// File: rtl/uart_tx_ctrl.sv
// UART transmit controller. One serial bit is sent per clk edge (clk is the baud clock).
// A frame is a start bit, LSB-first data, an optional parity bit and a stop bit.
//
// state  | meaning
// IDLE   | line held at 1, waiting for Data_Valid
// START  | start bit (0) on the line
// DATA   | data bits, LSB first, one per cycle
// PARITY | parity bit taken from the external calculator
// STOP   | stop bit (1); a new request may be accepted here
module uart_tx_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  par_bit,
    output logic                  TX_OUT,
    output logic                  busy
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [CW-1:0]         bit_cnt;
    logic                  par_en_q;
    logic                  accept;

    assign accept = Data_Valid && ((state == IDLE) || (state == STOP));

    // Outputs are registered alongside the state, so each branch loads the
    // line value that belongs to the state being entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            par_en_q  <= 1'b0;
            TX_OUT    <= 1'b1;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE, STOP: begin
                    if (accept) begin
                        shift_reg <= P_DATA;
                        par_en_q  <= PAR_EN;
                        bit_cnt   <= '0;
                        state     <= START;
                        TX_OUT    <= 1'b0;
                        busy      <= 1'b1;
                    end else begin
                        state  <= IDLE;
                        TX_OUT <= 1'b1;
                        busy   <= 1'b0;
                    end
                end
                START: begin
                    state     <= DATA;
                    TX_OUT    <= shift_reg[0];
                    shift_reg <= shift_reg >> 1;
                    busy      <= 1'b1;
                end
                DATA: begin
                    if (bit_cnt == LAST_BIT) begin
                        if (par_en_q) begin
                            state  <= PARITY;
                            TX_OUT <= par_bit;
                            busy   <= 1'b1;
                        end else begin
                            state  <= STOP;
                            TX_OUT <= 1'b1;
                            busy   <= 1'b0;
                        end
                    end else begin
                        bit_cnt   <= bit_cnt + 1'b1;
                        TX_OUT    <= shift_reg[0];
                        shift_reg <= shift_reg >> 1;
                        busy      <= 1'b1;
                    end
                end
                PARITY: begin
                    state  <= STOP;
                    TX_OUT <= 1'b1;
                    busy   <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    TX_OUT <= 1'b1;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: a frame-level model queues expected frames,
// and a line monitor decodes TX_OUT/busy every cycle and compares against the queue.
module tb_uart_tx_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] p_data = '0;
    logic         data_valid = 1'b0;
    logic         par_en = 1'b0;
    logic         par_bit = 1'b0;
    logic         tx_out;
    logic         busy;

    uart_tx_ctrl #(.DATA_WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .P_DATA    (p_data),
        .Data_Valid(data_valid),
        .PAR_EN    (par_en),
        .par_bit   (par_bit),
        .TX_OUT    (tx_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          start;
        int          len;
        logic [15:0] bits;
    } frame_t;

    frame_t exp_q[$];
    int total = 0;
    int bad = 0;
    int free_cyc = 0;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Model: the line is free for a new frame once the previous frame's stop cycle is reached.
    task automatic apply(input logic dv, input logic [W-1:0] d, input logic pe, input logic pb);
        frame_t f;
        data_valid = dv;
        p_data     = d;
        par_en     = pe;
        if (dv && rst && (cyc + 1 >= free_cyc)) begin
            par_bit = pb;
            f.start = cyc + 1;
            f.len   = W + 2 + (pe ? 1 : 0);
            f.bits  = '0;
            for (int i = 0; i < W; i++) f.bits[1+i] = d[i];
            if (pe) f.bits[W+1] = pb;
            f.bits[f.len-1] = 1'b1;
            exp_q.push_back(f);
            free_cyc = f.start + f.len;
        end
    endtask

    task automatic step(input logic dv, input logic [W-1:0] d, input logic pe, input logic pb);
        @(negedge clk);
        apply(dv, d, pe, pb);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, W'($urandom), 1'($urandom), 1'b0);
    endtask

    task automatic send_when_free(input logic [W-1:0] d, input logic pe, input logic pb);
        forever begin
            @(negedge clk);
            if (cyc + 1 >= free_cyc) break;
            apply(1'b0, W'($urandom), 1'($urandom), 1'b0);
        end
        apply(1'b1, d, pe, pb);
    endtask

    logic   in_frame = 1'b0;
    int     pos = 0;
    frame_t cur;

    always @(negedge clk) begin
        if (!rst) begin
            check("reset_tx", tx_out, 1);
            check("reset_busy", busy, 0);
            in_frame = 1'b0;
            exp_q.delete();
        end else if (in_frame) begin
            check("frame_bit", tx_out, cur.bits[pos]);
            check("frame_busy", busy, (pos < cur.len - 1) ? 1 : 0);
            pos++;
            if (pos == cur.len) in_frame = 1'b0;
        end else if (tx_out == 1'b0) begin
            check("frame_expected", (exp_q.size() > 0) ? 1 : 0, 1);
            if (exp_q.size() > 0) begin
                cur = exp_q.pop_front();
                check("start_cycle", cyc, cur.start);
                check("start_busy", busy, 1);
                pos      = 1;
                in_frame = 1'b1;
            end
        end else begin
            check("idle_busy", busy, 0);
        end
    end

    int a;

    initial begin
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        idle(5);

        send_when_free(8'hA5, 1'b0, 1'b0);
        idle(14);
        send_when_free(8'h0F, 1'b1, 1'b1);
        idle(14);

        send_when_free(8'h55, 1'b0, 1'b0);
        send_when_free(8'h33, 1'b0, 1'b0);
        idle(12);

        send_when_free(8'h00, 1'b0, 1'b0);
        idle(3);
        step(1'b1, 8'hFF, 1'b1, 1'b1);
        idle(15);

        send_when_free(8'h30, 1'b0, 1'b0);
        a = cyc + 1;
        while (cyc < a + 4) step(1'b0, W'($urandom), 1'($urandom), 1'b0);
        #1 rst = 1'b0;
        #1;
        check("async_reset_tx", tx_out, 1);
        check("async_reset_busy", busy, 0);
        free_cyc = 0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        step(1'b1, 8'h81, 1'b1, 1'b0);
        idle(16);

        repeat (600) step(1'($urandom_range(0, 3) == 0), W'($urandom), 1'($urandom), 1'($urandom));
        idle(20);

        check("queue_drained", exp_q.size(), 0);
        check("frame_closed", in_frame, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
